// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state codes,
// base opcode constants (also consumed by the decoder) and a legality helper.
package instr_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_sequencer_bus_wait_timer.sv
// Bus wait timer shared by the fetch and data-memory handshakes.
// Counts cycles a request is outstanding without an ack; 'expired' flags the
// TIMEOUT-th such cycle so the FSM can trap on the following edge. An ack in
// that same cycle keeps wait_en low, so the ack wins over the timeout.
module bus_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count;

    // Wait counter: cleared whenever no handshake is pending, counts stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wait_en) begin
            count <= count + CW'(1);
        end
    end

    assign expired = wait_en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer around the combinational instruction decoder.
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a terminal TRAP.
// Handshakes: a request stays high, with address/we stable, until the cycle in
// which the matching ack is sampled high; acks seen while no request is
// outstanding are ignored. All handshake and write-enable outputs are
// registered from the next state, so they are clean from the clock edge.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int          TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic            mem_to_reg,
    input  logic            sw,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic [XLEN-1:0] target_pc,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            reg_we,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     retired,
    output logic            trap,
    output logic [2:0]      dbg_state
);

    state_t          state;
    state_t          state_nxt;
    logic            fetch_done;
    logic            mem_done;
    logic            is_branch;
    logic            is_mem_op;
    logic            retire_now;
    logic            wait_en;
    logic            wait_clear;
    logic            wait_expired;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_nxt;

    assign imem_addr  = pc;
    assign dbg_state  = state;
    assign fetch_done = (state == ST_FETCH) && imem_req && imem_ack;
    assign mem_done   = (state == ST_MEM) && dmem_req && dmem_ack;
    assign is_branch  = (ir[6:0] == OP_BRANCH);
    assign is_mem_op  = mem_to_reg || sw;
    assign pc_plus4   = pc + XLEN'(4);

    assign wait_en    = ((state == ST_FETCH) && imem_req && !imem_ack) ||
                        ((state == ST_MEM)   && dmem_req && !dmem_ack);
    assign wait_clear = !wait_en;

    bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .wait_en (wait_en),
        .expired (wait_expired)
    );

    // Next-state selection for the sequencer FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (fetch_done)        state_nxt = ST_DECODE;
                else if (wait_expired) state_nxt = ST_TRAP;
            end
            ST_DECODE: state_nxt = is_legal_opcode(ir[6:0]) ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (is_mem_op)      state_nxt = ST_MEM;
                else if (is_branch) state_nxt = ST_FETCH;
                else                state_nxt = ST_WB;
            end
            ST_MEM: begin
                if (mem_done)          state_nxt = sw ? ST_FETCH : ST_WB;
                else if (wait_expired) state_nxt = ST_TRAP;
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_TRAP;
        endcase
    end

    // Retirement points and the PC value each one commits.
    always_comb begin
        retire_now = 1'b0;
        pc_nxt     = pc_plus4;
        case (state)
            ST_EXEC: begin
                retire_now = is_branch && !is_mem_op;
                pc_nxt     = (jump || branch_taken) ? target_pc : pc_plus4;
            end
            ST_MEM: begin
                retire_now = mem_done && sw;
                pc_nxt     = pc_plus4;
            end
            ST_WB: begin
                retire_now = 1'b1;
                pc_nxt     = (jump || (is_branch && branch_taken)) ? target_pc : pc_plus4;
            end
            default: begin
                retire_now = 1'b0;
                pc_nxt     = pc_plus4;
            end
        endcase
    end

    // State, architectural registers and registered handshake/enable outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            retired  <= '0;
            trap     <= 1'b0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_we   <= 1'b0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt == ST_FETCH);
            dmem_req <= (state_nxt == ST_MEM);
            dmem_we  <= (state_nxt == ST_MEM) && sw;
            reg_we   <= (state_nxt == ST_WB);
            trap     <= (state_nxt == ST_TRAP);
            if (fetch_done) begin
                ir <= imem_rdata;
            end
            if (retire_now) begin
                pc      <= pc_nxt;
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer. A small decoder model
// drives mem_to_reg/sw/jump/branch_taken from ir; an instruction-level
// reference model predicts pc, retired count, trap, reg_we pulses and data
// memory activity for every instruction.
module tb_instr_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        mem_to_reg;
    logic        sw;
    logic        branch_taken;
    logic        jump;
    logic [31:0] target_pc = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        reg_we;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        trap;
    logic [2:0]  dbg_state;

    logic        taken_sel = 1'b0;

    int          checks = 0;
    int          failures = 0;

    logic [31:0] exp_pc = '0;
    logic [31:0] exp_ret = '0;
    logic        exp_trap = 1'b0;

    instr_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .mem_to_reg   (mem_to_reg),
        .sw           (sw),
        .branch_taken (branch_taken),
        .jump         (jump),
        .target_pc    (target_pc),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .reg_we       (reg_we),
        .pc           (pc),
        .retired      (retired),
        .trap         (trap),
        .dbg_state    (dbg_state)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Decoder stand-in driven from the latched instruction.
    always_comb begin
        mem_to_reg   = (ir[6:0] == 7'b0000011);
        sw           = (ir[6:0] == 7'b0100011);
        jump         = (ir[6:0] == 7'b1101111);
        branch_taken = (ir[6:0] == 7'b1100011) && taken_sel;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
               (op == 7'h63) || (op == 7'h37) || (op == 7'h6F);
    endfunction

    // Async reset pulse mid-cycle, then post-reset and first-request checks.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("reset_async_imem_req", imem_req, 0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_pc = 32'h0; exp_ret = 32'h0; exp_trap = 1'b0;
        #1;
        check("reset_pc", pc, 0);
        check("reset_retired", retired, 0);
        check("reset_trap", trap, 0);
        check("reset_ir", ir, 0);
        check("reset_outs", {imem_req, dmem_req, dmem_we, reg_we}, 0);
        @(negedge clk);
        check("first_imem_req", imem_req, 1);
    endtask

    // Fetch one instruction after idly stall cycles, serve data memory after
    // ddly stall cycles, then compare against the instruction-level model.
    task automatic run_instr(input logic [31:0] instr, input logic tk, input logic [31:0] tgt,
                             input int idly, input int ddly);
        logic [6:0] op;
        int  n;
        int  we_cnt, dreq_cnt, dwe_cnt, overlap;
        bit  done, legal, writes, memop;
        op = instr[6:0];
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req_seen", imem_req, 1);
        taken_sel = tk;
        target_pc = tgt;
        for (int i = 0; i < idly; i++) begin
            check("imem_addr_stable", imem_addr, exp_pc);
            @(negedge clk);
        end
        check("imem_addr", imem_addr, exp_pc);
        imem_ack = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom();
        we_cnt = 0; dreq_cnt = 0; dwe_cnt = 0; overlap = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (trap === 1'b1 || imem_req === 1'b1) begin
                done = 1;
            end else begin
                if (reg_we) we_cnt++;
                if (dmem_req) begin
                    dreq_cnt++;
                    if (dmem_we) dwe_cnt++;
                    if (reg_we) overlap++;
                    dmem_ack = (dreq_cnt == ddly + 1);
                end else begin
                    dmem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        dmem_ack = 1'b0;
        check("instr_completed", done, 1);

        legal  = model_legal(op);
        memop  = legal && (op == 7'h03 || op == 7'h23);
        writes = legal && (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 || op == 7'h6F);
        if (!legal) begin
            exp_trap = 1'b1;
        end else begin
            exp_ret = exp_ret + 1;
            if (op == 7'h6F || (op == 7'h63 && tk)) exp_pc = tgt;
            else                                    exp_pc = exp_pc + 4;
        end
        check("ir_latched", ir, instr);
        check("pc", pc, exp_pc);
        check("retired", retired, exp_ret);
        check("trap", trap, exp_trap);
        check("reg_we_pulses", we_cnt, writes ? 1 : 0);
        check("dmem_req_cycles", dreq_cnt, memop ? ddly + 1 : 0);
        check("dmem_we_cycles", dwe_cnt, (memop && op == 7'h23) ? ddly + 1 : 0);
        check("reg_we_with_dmem_req", overlap, 0);
    endtask

    // Hold off imem_ack: trap must appear exactly after the TO-th stalled cycle.
    task automatic fetch_timeout();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_req_seen", imem_req, 1);
        for (int i = 0; i < TO; i++) begin
            check("timeout_not_yet", trap, 0);
            @(negedge clk);
        end
        exp_trap = 1'b1;
        check("timeout_trap", trap, 1);
        check("timeout_req_dropped", imem_req, 0);
        check("timeout_pc_frozen", pc, exp_pc);
        check("timeout_retired", retired, exp_ret);
    endtask

    logic [6:0]  legal_ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};
    logic [31:0] rbits;
    logic [31:0] frozen_pc;

    initial begin
        // Initial reset and reset in the middle of a pending fetch.
        do_reset();
        check("pre_reset_req_high", imem_req, 1);
        do_reset();

        // ADD, then LUI and JAL.
        run_instr(32'h002081B3, 1'b0, 32'h0, 0, 0);
        check("add_pc", pc, 32'h4);
        check("add_retired", retired, 32'd1);
        run_instr(32'h123450B7, 1'b0, 32'h0, 1, 0);
        run_instr(32'h0080006F, 1'b0, 32'h100, 2, 0);

        // LW (dmem stalls two cycles) then SW.
        do_reset();
        run_instr(32'h0040A103, 1'b0, 32'h0, 0, 2);
        run_instr(32'h0020A223, 1'b0, 32'h0, 0, 0);
        check("lw_sw_pc", pc, 32'h8);
        check("lw_sw_retired", retired, 32'd2);

        // BEQ taken then not taken.
        run_instr(32'h00208463, 1'b1, 32'h40, 0, 0);
        check("beq_taken_pc", pc, 32'h40);
        run_instr(32'h00208463, 1'b0, 32'h80, 0, 0);
        check("beq_not_taken_pc", pc, 32'h44);

        // Ack lands on the last allowed wait cycle: no trap.
        run_instr(32'h002081B3, 1'b0, 32'h0, TO - 1, 0);
        run_instr(32'h0040A103, 1'b0, 32'h0, 0, TO - 1);

        // Randomized instruction stream.
        for (int k = 0; k < 40; k++) begin
            rbits = $urandom();
            run_instr({rbits[31:7], legal_ops[$urandom_range(0, 6)]},
                      1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF), 2'b00},
                      $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end

        // Fetch timeout.
        fetch_timeout();

        // Illegal opcode traps; acks afterwards are ignored.
        do_reset();
        run_instr(32'h0000007F, 1'b0, 32'h0, 0, 0);
        frozen_pc = pc;
        for (int i = 0; i < 6; i++) begin
            imem_ack = ~imem_ack;
            imem_rdata = $urandom();
            @(negedge clk);
            check("trap_no_imem_req", imem_req, 0);
        end
        imem_ack = 1'b0;
        check("trap_sticky", trap, 1);
        check("trap_pc_frozen", pc, 32'h0);
        check("trap_ir_frozen", ir, 32'h0000007F);
        check("trap_pc_unchanged", pc, frozen_pc);

        // Recovery after reset.
        do_reset();
        run_instr(32'h002081B3, 1'b0, 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
